// File: rtl/mips_mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, functs,
// datapath select codes, FSM states and the decoded instruction class.
package mips_mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_OR   = 3'd2;
  localparam logic [2:0] ALU_LUI  = 3'd3;

  localparam logic [1:0] PCSEL_PC4    = 2'd0;
  localparam logic [1:0] PCSEL_BRANCH = 2'd1;
  localparam logic [1:0] PCSEL_JUMP   = 2'd2;
  localparam logic [1:0] PCSEL_RS     = 2'd3;

  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MDR = 2'd1;
  localparam logic [1:0] WD_PC  = 2'd2;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_e;

  // One-hot instruction class; all-zero means unsupported encoding.
  typedef struct packed {
    logic addu;
    logic subu;
    logic jr;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
  } iclass_t;

  // Full set of controller outputs, so reset gating is a single assignment.
  typedef struct packed {
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [1:0] wd_sel;
    logic       alu_src;
    logic       sign_ext;
    logic [2:0] alu_ctrl;
    logic       mem_we;
    logic       instr_done;
    logic       illegal;
  } ctl_t;

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// Controller <-> datapath bundle: IR fields and ALU flag in, control out.
interface mips_mc_ctrl_if;
  logic [5:0] op;
  logic [5:0] func;
  logic       zero;
  logic       ir_we;
  logic       pc_we;
  logic [1:0] pc_sel;
  logic       reg_we;
  logic [1:0] reg_dst;
  logic [1:0] wd_sel;
  logic       alu_src;
  logic       sign_ext;
  logic [2:0] alu_ctrl;
  logic       mem_we;
  logic       instr_done;
  logic       illegal;

  modport master (
    input  op, func, zero,
    output ir_we, pc_we, pc_sel, reg_we, reg_dst, wd_sel,
           alu_src, sign_ext, alu_ctrl, mem_we, instr_done, illegal
  );

  modport slave (
    output op, func, zero,
    input  ir_we, pc_we, pc_sel, reg_we, reg_dst, wd_sel,
           alu_src, sign_ext, alu_ctrl, mem_we, instr_done, illegal
  );
endinterface

// File: rtl/mips_mc_ctrl_decode.sv
// Combinational op/func -> one-hot instruction class plus illegal flag.
module mips_mc_decode
  import mips_mc_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output iclass_t    cls,
  output logic       is_illegal
);

  // Classify the IR; anything not matched leaves cls all-zero.
  always_comb begin
    cls = '0;
    case (op)
      OP_RTYPE: begin
        case (func)
          FN_ADDU: cls.addu = 1'b1;
          FN_SUBU: cls.subu = 1'b1;
          FN_JR:   cls.jr   = 1'b1;
          default: ;
        endcase
      end
      OP_J:    cls.j   = 1'b1;
      OP_JAL:  cls.jal = 1'b1;
      OP_BEQ:  cls.beq = 1'b1;
      OP_ORI:  cls.ori = 1'b1;
      OP_LUI:  cls.lui = 1'b1;
      OP_LW:   cls.lw  = 1'b1;
      OP_SW:   cls.sw  = 1'b1;
      default: ;
    endcase
    is_illegal = (cls == '0);
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB with parametrised
// instruction- and data-memory wait states.
module mips_mc_ctrl
  import mips_mc_ctrl_pkg::*;
#(
  parameter int IMEM_WAIT = 0,
  parameter int DMEM_WAIT = 0,
  parameter int CNT_W     = 4
) (
  input  logic           clk,
  input  logic           reset,
  mips_mc_ctrl_if.master bus
);

  localparam logic [CNT_W-1:0] IMEM_LIM = IMEM_WAIT[CNT_W-1:0];
  localparam logic [CNT_W-1:0] DMEM_LIM = DMEM_WAIT[CNT_W-1:0];

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  iclass_t          cls;
  logic             is_illegal;
  ctl_t             ctl_raw, ctl;

  mips_mc_decode u_dec (
    .op         (bus.op),
    .func       (bus.func),
    .cls        (cls),
    .is_illegal (is_illegal)
  );

  // State register and wait counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; counter runs only while a memory wait is pending and
  // restarts from zero on any state change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_FETCH: begin
        if (cnt_q == IMEM_LIM) state_d = ST_DECODE;
        else                   cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_DECODE: begin
        if (cls.j || cls.jal || cls.jr || is_illegal) state_d = ST_FETCH;
        else                                          state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (cls.lw || cls.sw) state_d = ST_MEM;
        else if (cls.beq)     state_d = ST_FETCH;
        else                  state_d = ST_WB;
      end
      ST_MEM: begin
        if (cnt_q == DMEM_LIM) state_d = cls.sw ? ST_FETCH : ST_WB;
        else                   cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_WB:   state_d = ST_FETCH;
      default: state_d = ST_FETCH;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // Output decode from state x class; ALU controls stay at their EXEC value
  // through MEM and WB since op/func are stable for the whole instruction.
  always_comb begin
    ctl_raw = '0;
    case (state_q)
      ST_FETCH: begin
        if (cnt_q == IMEM_LIM) begin
          ctl_raw.ir_we  = 1'b1;
          ctl_raw.pc_we  = 1'b1;
          ctl_raw.pc_sel = PCSEL_PC4;
        end
      end
      ST_DECODE: begin
        if (cls.j || cls.jal) begin
          ctl_raw.pc_we      = 1'b1;
          ctl_raw.pc_sel     = PCSEL_JUMP;
          ctl_raw.instr_done = 1'b1;
          if (cls.jal) begin
            ctl_raw.reg_we  = 1'b1;
            ctl_raw.reg_dst = DST_RA;
            ctl_raw.wd_sel  = WD_PC;
          end
        end else if (cls.jr) begin
          ctl_raw.pc_we      = 1'b1;
          ctl_raw.pc_sel     = PCSEL_RS;
          ctl_raw.instr_done = 1'b1;
        end else if (is_illegal) begin
          ctl_raw.illegal    = 1'b1;
          ctl_raw.instr_done = 1'b1;
        end
      end
      ST_EXEC, ST_MEM, ST_WB: begin
        ctl_raw.alu_src  = cls.ori || cls.lui || cls.lw || cls.sw;
        ctl_raw.sign_ext = cls.lw || cls.sw;
        if (cls.subu || cls.beq) ctl_raw.alu_ctrl = ALU_SUB;
        else if (cls.ori)        ctl_raw.alu_ctrl = ALU_OR;
        else if (cls.lui)        ctl_raw.alu_ctrl = ALU_LUI;
        else                     ctl_raw.alu_ctrl = ALU_ADD;
        case (state_q)
          ST_EXEC: begin
            if (cls.beq) begin
              ctl_raw.pc_sel     = PCSEL_BRANCH;
              ctl_raw.pc_we      = bus.zero;
              ctl_raw.instr_done = 1'b1;
            end
          end
          ST_MEM: begin
            if (cnt_q == DMEM_LIM && cls.sw) begin
              ctl_raw.mem_we     = 1'b1;
              ctl_raw.instr_done = 1'b1;
            end
          end
          default: begin
            ctl_raw.reg_we     = 1'b1;
            ctl_raw.instr_done = 1'b1;
            ctl_raw.reg_dst    = (cls.addu || cls.subu) ? DST_RD : DST_RT;
            ctl_raw.wd_sel     = cls.lw ? WD_MDR : WD_ALU;
          end
        endcase
      end
      default: ;
    endcase
  end

  // Everything is held low while reset is asserted, including the
  // FETCH-cycle enables that the reset state would otherwise produce.
  always_comb begin
    ctl = reset ? ctl_raw : '0;
    bus.ir_we      = ctl.ir_we;
    bus.pc_we      = ctl.pc_we;
    bus.pc_sel     = ctl.pc_sel;
    bus.reg_we     = ctl.reg_we;
    bus.reg_dst    = ctl.reg_dst;
    bus.wd_sel     = ctl.wd_sel;
    bus.alu_src    = ctl.alu_src;
    bus.sign_ext   = ctl.sign_ext;
    bus.alu_ctrl   = ctl.alu_ctrl;
    bus.mem_we     = ctl.mem_we;
    bus.instr_done = ctl.instr_done;
    bus.illegal    = ctl.illegal;
  end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Bench for mips_mc_ctrl: four instances with different wait-state settings,
// a per-cycle expected-control scoreboard built from the ISA description.
module tb_mips_mc_ctrl;
  import mips_mc_ctrl_pkg::*;

  localparam int NDUT = 4;

  // dut0: W0 D0, dut1: W0 D2, dut2: W1 D0, dut3: W0 D3
  function automatic int w_of(int k);
    return (k == 2) ? 1 : 0;
  endfunction
  function automatic int d_of(int k);
    return (k == 1) ? 2 : (k == 3) ? 3 : 0;
  endfunction

  logic            clk = 1'b0;
  logic [NDUT-1:0] rst_n;
  logic [5:0]      op, func;
  logic            zero;
  ctl_t [NDUT-1:0] obs;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    mips_mc_ctrl_if bus();
    assign bus.op   = op;
    assign bus.func = func;
    assign bus.zero = zero;
    mips_mc_ctrl #(.IMEM_WAIT(w_of(g)), .DMEM_WAIT(d_of(g)), .CNT_W(4)) dut (
      .clk   (clk),
      .reset (rst_n[g]),
      .bus   (bus)
    );
    assign obs[g] = '{bus.ir_we, bus.pc_we, bus.pc_sel, bus.reg_we, bus.reg_dst,
                      bus.wd_sel, bus.alu_src, bus.sign_ext, bus.alu_ctrl,
                      bus.mem_we, bus.instr_done, bus.illegal};
  end

  ctl_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic cmp(string tag, ctl_t got, ctl_t expv);
    total++;
    assert (got === expv) else begin
      bad++;
      $error("FAIL %s got=%05h exp=%05h", tag, got, expv);
    end
  endtask

  // Expected per-cycle control trace for one instruction on a W/D controller.
  task automatic model(int k, logic [5:0] o, logic [5:0] f, logic z);
    ctl_t c, alu;
    bit rt   = (o == 6'h00);
    bit addu = rt && f == 6'h21;
    bit subu = rt && f == 6'h23;
    bit jr   = rt && f == 6'h08;
    bit ori  = o == 6'h0D, lui = o == 6'h0F, lw = o == 6'h23, sw = o == 6'h2B;
    bit beq  = o == 6'h04, j = o == 6'h02, jal = o == 6'h03;
    bit ill  = !(addu || subu || jr || ori || lui || lw || sw || beq || j || jal);
    for (int i = 0; i <= w_of(k); i++) begin
      c = '0;
      if (i == w_of(k)) begin c.ir_we = 1; c.pc_we = 1; c.pc_sel = 2'd0; end
      exp_q.push_back(c);
    end
    c = '0;
    if (j || jal) begin
      c.pc_we = 1; c.pc_sel = 2'd2; c.instr_done = 1;
      if (jal) begin c.reg_we = 1; c.reg_dst = 2'd2; c.wd_sel = 2'd2; end
    end else if (jr) begin
      c.pc_we = 1; c.pc_sel = 2'd3; c.instr_done = 1;
    end else if (ill) begin
      c.illegal = 1; c.instr_done = 1;
    end
    exp_q.push_back(c);
    if (j || jal || jr || ill) return;
    alu = '0;
    if (subu || beq) alu.alu_ctrl = 3'd1;
    if (ori)  begin alu.alu_src = 1; alu.alu_ctrl = 3'd2; end
    if (lui)  begin alu.alu_src = 1; alu.alu_ctrl = 3'd3; end
    if (lw || sw) begin alu.alu_src = 1; alu.sign_ext = 1; end
    c = alu;
    if (beq) begin c.pc_sel = 2'd1; c.pc_we = z; c.instr_done = 1; end
    exp_q.push_back(c);
    if (beq) return;
    if (lw || sw) begin
      for (int i = 0; i <= d_of(k); i++) begin
        c = alu;
        if (i == d_of(k) && sw) begin c.mem_we = 1; c.instr_done = 1; end
        exp_q.push_back(c);
      end
      if (sw) return;
    end
    c = alu;
    c.reg_we = 1; c.instr_done = 1;
    c.reg_dst = (addu || subu) ? 2'd1 : 2'd0;
    c.wd_sel  = lw ? 2'd1 : 2'd0;
    exp_q.push_back(c);
  endtask

  // Drive one instruction and compare every cycle (or only the first lim).
  task automatic run(int k, string nm, logic [5:0] o, logic [5:0] f, logic z, int lim);
    int i = 0;
    ctl_t e;
    op = o; func = f; zero = z;
    model(k, o, f, z);
    #1;
    while (exp_q.size() > 0 && (lim < 0 || i < lim)) begin
      e = exp_q.pop_front();
      cmp($sformatf("u%0d_%s[%0d]", k, nm, i), obs[k], e);
      i++;
      @(posedge clk); #1;
    end
    exp_q.delete();
  endtask

  task automatic select(int k);
    @(posedge clk); #1;
    rst_n = '0;
    @(posedge clk); #1;
    rst_n[k] = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_n = '0; op = 6'h3F; func = 6'h00; zero = 1'b0;
    #12;
    for (int k = 0; k < NDUT; k++) cmp($sformatf("reset%0d", k), obs[k], '0);
    @(posedge clk); #1;
    cmp("reset_clk", obs[0], '0);

    select(0);
    run(0, "addu",  6'h00, 6'h21, 1'b0, -1);
    run(0, "subu",  6'h00, 6'h23, 1'b0, -1);
    run(0, "ori",   6'h0D, 6'h00, 1'b0, -1);
    run(0, "lui",   6'h0F, 6'h00, 1'b0, -1);
    run(0, "beq_nt",6'h04, 6'h00, 1'b0, -1);
    run(0, "beq_t", 6'h04, 6'h00, 1'b1, -1);
    run(0, "j",     6'h02, 6'h00, 1'b0, -1);
    run(0, "jr",    6'h00, 6'h08, 1'b0, -1);
    run(0, "ill_op",6'h3F, 6'h00, 1'b0, -1);
    run(0, "ill_fn",6'h00, 6'h20, 1'b0, -1);
    run(0, "sw",    6'h2B, 6'h00, 1'b0, -1);
    run(0, "lw",    6'h23, 6'h00, 1'b0, -1);

    select(1);
    run(1, "lw",    6'h23, 6'h00, 1'b0, -1);
    run(1, "sw",    6'h2B, 6'h00, 1'b0, -1);

    select(2);
    run(2, "jal",   6'h03, 6'h00, 1'b0, -1);
    run(2, "addu",  6'h00, 6'h21, 1'b0, -1);

    // sw with D=3: reset lands on the 2nd MEM cycle (F,D,E,M1 checked first)
    select(3);
    run(3, "sw_cut", 6'h2B, 6'h00, 1'b0, 4);
    rst_n[3] = 1'b0;
    #1;
    cmp("rst_mid", obs[3], '0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cmp($sformatf("rst_hold[%0d]", i), obs[3], '0);
    end
    @(posedge clk); #1;
    rst_n[3] = 1'b1;
    run(3, "post_rst_addu", 6'h00, 6'h21, 1'b0, -1);
    run(3, "sw",    6'h2B, 6'h00, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
